// File: rtl/sram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sram_arb_pkg
// Shared types for the single-port SRAM read/write arbiter.
//   ARB_AW / ARB_DW : default address / data widths of the buffer RAM wrappers
//   gnt_e           : per-cycle SRAM grant (idle, read, write)
//   wentry_t        : one posted-write entry {addr, data}
// -----------------------------------------------------------------------------
package sram_arb_pkg;

    localparam int ARB_AW = 6;
    localparam int ARB_DW = 288;

    typedef enum logic [1:0] {
        GNT_IDLE  = 2'd0,
        GNT_READ  = 2'd1,
        GNT_WRITE = 2'd2
    } gnt_e;

    typedef struct packed {
        logic [ARB_AW-1:0] addr;
        logic [ARB_DW-1:0] data;
    } wentry_t;

endpackage

// File: rtl/sram_arb_wbuf.sv
// -----------------------------------------------------------------------------
// sram_arb_wbuf
// Posted-write FIFO for the SRAM arbiter. Besides the usual head/full/empty
// view it compares every valid entry against a probe address and returns the
// data of the youngest matching entry (used for read-after-write handling).
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset (drops contents)
//   push, push_addr/data enqueue one entry (caller guarantees !full)
//   pop                 dequeue head (caller guarantees !empty)
//   cmp_addr            probe address for hazard compare
//   full, empty         occupancy flags
//   head_addr/head_data oldest entry
//   hit_vec             per-slot match of cmp_addr against valid entries
//   hit_data            data of the youngest matching entry ('0 if none)
// -----------------------------------------------------------------------------
module sram_arb_wbuf
    import sram_arb_pkg::*;
#(
    parameter int AW    = ARB_AW,
    parameter int DW    = ARB_DW,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [AW-1:0]    push_addr,
    input  logic [DW-1:0]    push_data,
    input  logic             pop,
    input  logic [AW-1:0]    cmp_addr,
    output logic             full,
    output logic             empty,
    output logic [AW-1:0]    head_addr,
    output logic [DW-1:0]    head_data,
    output logic [DEPTH-1:0] hit_vec,
    output logic [DW-1:0]    hit_data
);

    localparam int PW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW:0]   wr_ptr_reg;
    logic [PW:0]   rd_ptr_reg;
    logic [PW-1:0] wr_idx;
    logic [PW-1:0] rd_idx;
    logic [PW-1:0] scan_idx;

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    assign wr_idx = wr_ptr_reg[PW-1:0];
    assign rd_idx = rd_ptr_reg[PW-1:0];

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) && (wr_idx == rd_idx);

    assign head_addr = addr_mem[rd_idx];
    assign head_data = data_mem[rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + (PW+1)'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + (PW+1)'(1);
            end
        end
    end

    // Entry payload needs no reset: validity is tracked separately.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_idx] <= push_addr;
            data_mem[wr_idx] <= push_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic valid_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                end else if (push && (wr_idx == PW'(gi))) begin
                    valid_reg <= 1'b1;
                end else if (pop && (rd_idx == PW'(gi))) begin
                    valid_reg <= 1'b0;
                end
            end

            assign hit_vec[gi] = valid_reg && (addr_mem[gi] == cmp_addr);
        end
    endgenerate

    // Walk slots from oldest to youngest; the last hit seen wins, which gives
    // the most recently posted value for that address.
    always_comb begin
        hit_data = '0;
        scan_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = rd_idx + PW'(k);
            if (hit_vec[scan_idx]) begin
                hit_data = data_mem[scan_idx];
            end
        end
    end

endmodule

// File: rtl/sram_1p_rw_arbiter.sv
// -----------------------------------------------------------------------------
// sram_1p_rw_arbiter
// Shares one single-port SRAM (active-low CEB/WEB, 1-cycle read latency)
// between an independent read requester and a posted-write requester.
// Reads win by default; a buffered write is forced out when the buffer is
// full or after MAX_RD_STREAK consecutive reads. Reads that hit a buffered
// write are stalled until the buffer drains the match, or -- with the
// SRAM_ARB_RAW_FWD_EN macro defined -- are answered from the buffer without
// touching the SRAM.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   rd_valid/rd_ready/rd_addr    read request channel
//   rsp_valid/rsp_data           read response, one cycle after rd_ready
//   wr_valid/wr_ready/wr_addr/wr_data  posted-write channel
//   mem_ceb/mem_web/mem_addr/mem_wdata/mem_rdata  SRAM macro interface
//   busy                         write buffer non-empty or response pending
//
// Build option: `define SRAM_ARB_RAW_FWD_EN for read-after-write forwarding.
// -----------------------------------------------------------------------------
module sram_1p_rw_arbiter
    import sram_arb_pkg::*;
#(
    parameter int AW            = ARB_AW,
    parameter int DW            = ARB_DW,
    parameter int WBUF_DEPTH    = 2,
    parameter int MAX_RD_STREAK = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_valid,
    output logic          rd_ready,
    input  logic [AW-1:0] rd_addr,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          mem_ceb,
    output logic          mem_web,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int SW = $clog2(MAX_RD_STREAK + 1);

    gnt_e                  gnt;
    logic                  buf_full;
    logic                  buf_empty;
    logic [AW-1:0]         head_addr;
    logic [DW-1:0]         head_data;
    logic [WBUF_DEPTH-1:0] hit_vec;
    logic [DW-1:0]         fwd_data;

    logic                  wr_push;
    logic                  wr_pop;
    logic                  rd_hazard;
    logic                  rd_blocked;
    logic                  rd_go;
    logic                  rd_fwd;

    logic [SW-1:0]         streak_reg;
    logic                  rsp_valid_reg;
    logic                  rsp_from_mem_reg;
    logic [DW-1:0]         rsp_data_reg;

    sram_arb_wbuf #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_push),
        .push_addr (wr_addr),
        .push_data (wr_data),
        .pop       (wr_pop),
        .cmp_addr  (rd_addr),
        .full      (buf_full),
        .empty     (buf_empty),
        .head_addr (head_addr),
        .head_data (head_data),
        .hit_vec   (hit_vec),
        .hit_data  (fwd_data)
    );

    // Ready depends only on registered occupancy, never on this cycle's pop.
    assign wr_ready = !buf_full;
    assign wr_push  = wr_valid && wr_ready;
    assign wr_pop   = (gnt == GNT_WRITE);

    // A write accepted this cycle is not yet in the buffer, so it cannot
    // raise a hazard for a read presented in the same cycle.
    assign rd_hazard  = rd_valid && (|hit_vec);
    assign rd_blocked = !buf_empty && (buf_full || (streak_reg == SW'(MAX_RD_STREAK)));

`ifdef SRAM_ARB_RAW_FWD_EN
    assign rd_fwd = rd_hazard;
    assign rd_go  = rd_valid && !rd_blocked;
`else
    assign rd_fwd = 1'b0;
    assign rd_go  = rd_valid && !rd_hazard && !rd_blocked;
`endif

    // Grant is forced idle while reset is held so the SRAM controls fall
    // back to their inactive values without waiting for a clock edge.
    always_comb begin
        gnt = GNT_IDLE;
        if (!rst) begin
            if (rd_go) begin
                gnt = GNT_READ;
            end else if (!buf_empty) begin
                gnt = GNT_WRITE;
            end
        end
    end

    assign rd_ready = (gnt == GNT_READ);

    always_comb begin
        mem_ceb   = 1'b1;
        mem_web   = 1'b1;
        mem_addr  = '0;
        mem_wdata = '0;
        case (gnt)
            GNT_READ: begin
                // Forwarded reads are served from the buffer; SRAM stays off.
                mem_ceb  = rd_fwd;
                mem_addr = rd_addr;
            end
            GNT_WRITE: begin
                mem_ceb   = 1'b0;
                mem_web   = 1'b0;
                mem_addr  = head_addr;
                mem_wdata = head_data;
            end
            default: begin
            end
        endcase
    end

    // Counts reads granted while a write waits; saturates at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_reg <= '0;
        end else if ((gnt == GNT_WRITE) || buf_empty) begin
            streak_reg <= '0;
        end else if ((gnt == GNT_READ) && (streak_reg != SW'(MAX_RD_STREAK))) begin
            streak_reg <= streak_reg + SW'(1);
        end
    end

    // The SRAM output register already holds the read data in the response
    // cycle, so an SRAM-sourced response passes mem_rdata straight through and
    // latches it for later cycles. Forwarded data is captured at grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_reg    <= 1'b0;
            rsp_from_mem_reg <= 1'b0;
            rsp_data_reg     <= '0;
        end else begin
            rsp_valid_reg    <= (gnt == GNT_READ);
            rsp_from_mem_reg <= (gnt == GNT_READ) && !rd_fwd;
            if ((gnt == GNT_READ) && rd_fwd) begin
                rsp_data_reg <= fwd_data;
            end else if (rsp_from_mem_reg) begin
                rsp_data_reg <= mem_rdata;
            end
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_from_mem_reg ? mem_rdata : rsp_data_reg;
    assign busy      = !buf_empty || rsp_valid_reg;

endmodule

// File: tb/tb_sram_1p_rw_arbiter.sv
module tb_sram_1p_rw_arbiter;

    localparam int AW = 6;
    localparam int DW = 288;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rd_valid = 1'b0;
    logic          rd_ready;
    logic [AW-1:0] rd_addr = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          mem_ceb;
    logic          mem_web;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_1p_rw_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_addr   (rd_addr),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .mem_ceb   (mem_ceb),
        .mem_web   (mem_web),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // Behavioural single-port SRAM with one-cycle read latency.
    logic [DW-1:0] sram [64];
    always @(posedge clk) begin
        if (!mem_ceb) begin
            if (!mem_web) sram[mem_addr] <= mem_wdata;
            else          mem_rdata      <= sram[mem_addr];
        end
    end

    // Reference: the value a read must return is whatever was most recently
    // accepted for that address strictly before the read was granted.
    logic [DW-1:0] model [64];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] exp_v;

    task automatic check_d(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_i(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        d = '0;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (rsp_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rsp_unexpected actual=rsp_valid required=no_response");
                end else begin
                    exp_v = exp_q.pop_front();
                    checks--;
                    check_d("rsp_data", rsp_data, exp_v);
                    $display("RSP t=%0t data[31:0]=%08h", $time, rsp_data[31:0]);
                end
            end
            if (rd_valid && rd_ready) begin
                exp_q.push_back(model[rd_addr]);
                $display("RD  t=%0t addr=%0d", $time, rd_addr);
            end
            if (wr_valid && wr_ready) begin
                model[wr_addr] = wr_data;
                $display("WR  t=%0t addr=%0d data[31:0]=%08h", $time, wr_addr, wr_data[31:0]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        n = 0;
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        forever begin
            @(negedge clk);
            if (wr_ready) break;
            n++;
            if (n > 50) begin
                check_i("wr_accept_timeout", n, 0);
                break;
            end
            step();
        end
        step();
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, output int waits, output int ceb_g);
        waits = 0; ceb_g = -1;
        rd_valid = 1'b1; rd_addr = a;
        forever begin
            @(negedge clk);
            if (rd_ready) begin
                ceb_g = int'(mem_ceb);
                break;
            end
            waits++;
            if (waits > 50) begin
                check_i("rd_accept_timeout", waits, 0);
                break;
            end
            step();
        end
        step();
        rd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        rd_valid = 1'b0; wr_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (n > 50) begin
                check_i("idle_timeout", n, 0);
                break;
            end
        end
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int waits, ceb_g, nrd, first_w, cnt, third_c, wi, nwr;
        int g [$];
        logic [11:0] rdy_hist, w_hist;
        logic acc;
        logic [DW-1:0] pat_a5, d;

        for (int i = 0; i < 64; i++) begin
            sram[i]  = '0;
            model[i] = '0;
        end
        pat_a5 = {36{8'hA5}};

        // ---- reset state (read request held to confirm it is ignored) ----
        rd_valid = 1'b1; rd_addr = 6'd9;
        repeat (3) @(negedge clk);
        check_i("rst_mem_ceb",   int'(mem_ceb),   1);
        check_i("rst_mem_web",   int'(mem_web),   1);
        check_i("rst_mem_addr",  int'(mem_addr),  0);
        check_d("rst_mem_wdata", mem_wdata, '0);
        check_i("rst_rsp_valid", int'(rsp_valid), 0);
        check_d("rst_rsp_data",  rsp_data, '0);
        check_i("rst_busy",      int'(busy),      0);
        check_i("rst_rd_ready",  int'(rd_ready),  0);
        rd_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_i("post_rst_wr_ready", int'(wr_ready), 1);
        step();

        // ---- write 5 then read 5 ----
        do_write(6'd5, pat_a5);
        check_i("t1_wr_ceb",  int'(mem_ceb), 0);
        check_i("t1_wr_web",  int'(mem_web), 0);
        check_i("t1_wr_addr", int'(mem_addr), 5);
        check_d("t1_wr_data", mem_wdata, pat_a5);
        step();
        do_read(6'd5, waits, ceb_g);
        check_i("t1_rd_waits", waits, 0);
        @(negedge clk);
        check_i("t1_rsp_valid", int'(rsp_valid), 1);
        check_d("t1_rsp_data", rsp_data, pat_a5);
        step();

        // ---- read streak against one buffered write ----
        wait_idle();
        rd_valid = 1'b1; rd_addr = 6'd0;
        wr_valid = 1'b1; wr_addr = 6'd40; wr_data = rnd_data();
        nrd = 0;
        for (int c = 0; c < 30 && nrd < 10; c++) begin
            @(negedge clk);
            g.push_back(rd_ready ? 1 : ((!mem_ceb && !mem_web) ? 2 : 0));
            acc = wr_valid && wr_ready;
            if (rd_ready) nrd++;
            step();
            if (acc) wr_valid = 1'b0;
            rd_addr = AW'(nrd);
        end
        rd_valid = 1'b0;
        first_w = -1;
        for (int i = 0; i < g.size(); i++) if (g[i] == 2 && first_w < 0) first_w = i;
        cnt = 0;
        for (int i = 1; i < g.size() && i != first_w; i++) if (g[i] == 1) cnt++;
        check_i("t2_first_grant_read", g[0], 1);
        check_i("t2_streak_reads", cnt, 4);
        check_i("t2_write_slot", first_w, 5);
        check_i("t2_reads_resume", (first_w >= 0 && first_w + 1 < g.size()) ? g[first_w+1] : -1, 1);
        check_i("t2_total_grants", g.size(), 11);

        // ---- buffer full with reads held ----
        wait_idle();
        rd_valid = 1'b1; rd_addr = 6'd50;
        wi = 0; third_c = -1; rdy_hist = '0; w_hist = '0;
        wr_valid = 1'b1; wr_addr = 6'd20; wr_data = rnd_data();
        for (int c = 0; c < 12 && wi < 3; c++) begin
            @(negedge clk);
            rdy_hist[c] = wr_ready;
            w_hist[c]   = !mem_ceb && !mem_web;
            if (wr_ready) begin
                wi++;
                if (wi == 3) third_c = c;
            end
            step();
            if (wi == 3) wr_valid = 1'b0;
            else begin wr_addr = AW'(20 + wi); wr_data = rnd_data(); end
        end
        rd_valid = 1'b0;
        check_i("t3_ready_c1", int'(rdy_hist[1]), 1);
        check_i("t3_ready_full", int'(rdy_hist[2]), 0);
        check_i("t3_write_forced", int'(w_hist[2]), 1);
        check_i("t3_no_write_c1", int'(w_hist[1]), 0);
        check_i("t3_third_accept", third_c, 3);

        // ---- write 7 then immediately read 7 ----
        wait_idle();
        do_write(6'd7, DW'(1));
        do_read(6'd7, waits, ceb_g);
`ifdef SRAM_ARB_RAW_FWD_EN
        check_i("t4_rd_waits", waits, 0);
        check_i("t4_ceb_at_grant", ceb_g, 1);
`else
        check_i("t4_rd_waits", waits, 1);
        check_i("t4_ceb_at_grant", ceb_g, 0);
`endif
        @(negedge clk);
        check_i("t4_rsp_valid", int'(rsp_valid), 1);
        check_d("t4_rsp_data", rsp_data, DW'(1));
        step();

        // ---- two writes to 3, then read 3 ----
        wait_idle();
        rd_valid = 1'b1; rd_addr = 6'd50;
        wr_valid = 1'b1; wr_addr = 6'd3; wr_data = DW'(8'h11);
        @(negedge clk);
        check_i("t5_push1", int'(wr_ready), 1);
        step();
        wr_data = DW'(8'h22);
        @(negedge clk);
        check_i("t5_push2", int'(wr_ready), 1);
        step();
        wr_valid = 1'b0; rd_valid = 1'b0;
        do_read(6'd3, waits, ceb_g);
`ifdef SRAM_ARB_RAW_FWD_EN
        check_i("t5_rd_waits", waits, 1);
`else
        check_i("t5_rd_waits", waits, 2);
`endif
        @(negedge clk);
        check_d("t5_rsp_data", rsp_data, DW'(8'h22));
        step();

        // ---- reset during a read grant with writes pending ----
        wait_idle();
        rd_valid = 1'b1; rd_addr = 6'd60;
        wr_valid = 1'b1; wr_addr = 6'd30; wr_data = rnd_data();
        @(negedge clk);
        step();
        wr_addr = 6'd31; wr_data = rnd_data();
        @(negedge clk);
        check_i("t6_read_grant", int'(rd_ready), 1);
        #1 rst = 1'b1;
        #1;
        check_i("t6_async_ceb", int'(mem_ceb), 1);
        check_i("t6_async_rd_ready", int'(rd_ready), 0);
        check_i("t6_async_busy", int'(busy), 0);
        rd_valid = 1'b0; wr_valid = 1'b0;
        @(negedge clk);
        check_i("t6_rsp_squash", int'(rsp_valid), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 64; i++) model[i] = sram[i];
        nwr = 0;
        repeat (6) begin
            @(negedge clk);
            if (!mem_ceb && !mem_web) nwr++;
        end
        check_i("t6_no_write_after_rst", nwr, 0);
        check_i("t6_wr_ready", int'(wr_ready), 1);
        step();

        // ---- randomized traffic on a small address set ----
        for (int c = 0; c < 1500; c++) begin
            rd_valid = ($urandom_range(0, 9) < 6);
            rd_addr  = AW'($urandom_range(0, 7));
            wr_valid = ($urandom_range(0, 1) == 1);
            wr_addr  = AW'($urandom_range(0, 7));
            d = rnd_data();
            wr_data  = d;
            step();
        end
        wait_idle();
        repeat (2) step();
        @(negedge clk);
        check_i("end_busy", int'(busy), 0);
        check_i("end_pending_rsp", exp_q.size(), 0);
        check_i("end_wr_ready", int'(wr_ready), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
